// File: rtl/game_manager.sv
// Session controller: menu -> start -> play -> game-over sequencing, per-game
// reset/key gating, registered colour mux and score bookkeeping.
module game_manager #(
  parameter int NUM_GAMES        = 3,
  parameter int OVER_HOLD_FRAMES = 180,
  parameter int START_FRAMES     = 2,
  parameter logic [7:0] KEY_UP    = 8'h1D,
  parameter logic [7:0] KEY_DOWN  = 8'h1B,
  parameter logic [7:0] KEY_ENTER = 8'h5A,
  parameter logic [7:0] KEY_ESC   = 8'h76
) (
  input  logic                      clk2,
  input  logic                      rst,
  input  logic                      VS,
  input  logic [7:0]                keyboard,
  input  logic                      valid,
  input  logic [11:0]               menu_rgb,
  input  logic [12*NUM_GAMES-1:0]   game_rgb,
  input  logic [NUM_GAMES-1:0]      game_over_in,
  input  logic [14*NUM_GAMES-1:0]   score_in,
  output logic [NUM_GAMES-1:0]      game_rst,
  output logic [NUM_GAMES-1:0]      game_valid,
  output logic [3:0]                red,
  output logic [3:0]                green,
  output logic [3:0]                blue,
  output logic [1:0]                cursor,
  output logic [1:0]                state,
  output logic [13:0]               last_score,
  output logic [14*NUM_GAMES-1:0]   high_score
);

  typedef enum logic [1:0] {
    ST_MENU  = 2'd0,
    ST_START = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [1:0] LAST_IDX   = 2'(NUM_GAMES - 1);
  localparam logic [7:0] START_LAST = 8'(START_FRAMES - 1);
  localparam logic [7:0] OVER_LAST  = 8'(OVER_HOLD_FRAMES - 1);

  state_t                    state_q, state_d;
  logic [2:0]                vs_sr_q, vs_sr_d;
  logic [1:0]                cursor_q, cursor_d;
  logic [1:0]                active_q, active_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [NUM_GAMES-1:0]      game_rst_q, game_rst_d;
  logic [11:0]               rgb_q, rgb_d;
  logic [13:0]               last_score_q, last_score_d;
  logic [14*NUM_GAMES-1:0]   high_score_q, high_score_d;

  logic        tick;
  logic        key_up, key_down, key_enter, key_esc;
  logic [13:0] act_score;
  logic [13:0] act_high;
  logic [11:0] act_rgb;
  logic        in_game;

  // One tick per falling VS edge, seen through the synchroniser history.
  assign tick      = (vs_sr_q[2:1] == 2'b10);
  assign key_up    = valid && (keyboard == KEY_UP);
  assign key_down  = valid && (keyboard == KEY_DOWN);
  assign key_enter = valid && (keyboard == KEY_ENTER);
  assign key_esc   = valid && (keyboard == KEY_ESC);
  assign in_game   = (state_q == ST_PLAY) || (state_q == ST_OVER);

  assign act_score = score_in[int'(active_q)*14 +: 14];
  assign act_high  = high_score_q[int'(active_q)*14 +: 14];
  assign act_rgb   = game_rgb[int'(active_q)*12 +: 12];

  always_comb begin
    state_d      = state_q;
    vs_sr_d      = {vs_sr_q[1:0], VS};
    cursor_d     = cursor_q;
    active_d     = active_q;
    cnt_d        = cnt_q;
    last_score_d = last_score_q;
    high_score_d = high_score_q;
    case (state_q)
      ST_MENU: begin
        if (key_up) begin
          cursor_d = (cursor_q == 2'd0) ? LAST_IDX : cursor_q - 2'd1;
        end else if (key_down) begin
          cursor_d = (cursor_q == LAST_IDX) ? 2'd0 : cursor_q + 2'd1;
        end else if (key_enter) begin
          active_d = cursor_q;
          cnt_d    = 8'd0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == START_LAST) state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // game_over takes priority over an ESC in the same cycle
        if (game_over_in[active_q]) begin
          last_score_d = act_score;
          if (act_score > act_high) high_score_d[int'(active_q)*14 +: 14] = act_score;
          cnt_d   = 8'd0;
          state_d = ST_OVER;
        end else if (key_esc) begin
          state_d = ST_MENU;
        end
      end
      ST_OVER: begin
        if (tick) cnt_d = cnt_q + 8'd1;
        if (key_enter || (tick && cnt_q == OVER_LAST)) state_d = ST_MENU;
      end
      default: state_d = ST_MENU;
    endcase
  end

  always_comb begin
    game_rst_d = '1;
    game_valid = '0;
    for (int g = 0; g < NUM_GAMES; g++) begin
      if (g == int'(active_q) && in_game) game_rst_d[g] = 1'b0;
      game_valid[g] = valid && (g == int'(active_q)) && (state_q == ST_PLAY)
                      && (keyboard != KEY_ESC);
    end
    rgb_d = in_game ? act_rgb : menu_rgb;
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      state_q      <= ST_MENU;
      vs_sr_q      <= 3'b000;
      cursor_q     <= 2'd0;
      active_q     <= 2'd0;
      cnt_q        <= 8'd0;
      game_rst_q   <= '1;
      rgb_q        <= 12'd0;
      last_score_q <= 14'd0;
      high_score_q <= '0;
    end else begin
      state_q      <= state_d;
      vs_sr_q      <= vs_sr_d;
      cursor_q     <= cursor_d;
      active_q     <= active_d;
      cnt_q        <= cnt_d;
      game_rst_q   <= game_rst_d;
      rgb_q        <= rgb_d;
      last_score_q <= last_score_d;
      high_score_q <= high_score_d;
    end
  end

  assign state      = state_q;
  assign cursor     = cursor_q;
  assign game_rst   = game_rst_q;
  assign red        = rgb_q[11:8];
  assign green      = rgb_q[7:4];
  assign blue       = rgb_q[3:0];
  assign last_score = last_score_q;
  assign high_score = high_score_q;

endmodule

// File: tb/tb_game_manager.sv
// Directed bench for game_manager: expected values queued as stimulus is
// applied, popped and asserted when the DUT outputs are sampled.
module tb_game_manager;

  localparam int NG = 3;
  localparam logic [7:0] K_UP = 8'h1D, K_DOWN = 8'h1B, K_ENTER = 8'h5A, K_ESC = 8'h76;
  localparam logic [11:0] MENU_C = 12'h7E2;

  logic              clk2 = 1'b0;
  logic              rst = 1'b1;
  logic              VS = 1'b0;
  logic [7:0]        keyboard = 8'h00;
  logic              valid = 1'b0;
  logic [11:0]       menu_rgb = MENU_C;
  logic [12*NG-1:0]  game_rgb = {12'h333, 12'hA5C, 12'h111};
  logic [NG-1:0]     game_over_in = '0;
  logic [14*NG-1:0]  score_in = '0;
  logic [NG-1:0]     game_rst, game_valid;
  logic [3:0]        red, green, blue;
  logic [1:0]        cursor, state;
  logic [13:0]       last_score;
  logic [14*NG-1:0]  high_score;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  game_manager dut (
    .clk2(clk2), .rst(rst), .VS(VS), .keyboard(keyboard), .valid(valid),
    .menu_rgb(menu_rgb), .game_rgb(game_rgb), .game_over_in(game_over_in),
    .score_in(score_in), .game_rst(game_rst), .game_valid(game_valid),
    .red(red), .green(green), .blue(blue), .cursor(cursor), .state(state),
    .last_score(last_score), .high_score(high_score)
  );

  always #5 clk2 = ~clk2;

  task automatic exp_push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = exp_q.pop_front();
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk2);
  endtask

  task automatic key(input logic [7:0] code);
    keyboard = code;
    valid = 1'b1;
    @(negedge clk2);
    valid = 1'b0;
    keyboard = 8'h00;
  endtask

  task automatic frame();
    VS = 1'b1;
    cycles(4);
    VS = 1'b0;
    cycles(4);
  endtask

  task automatic start_game();
    key(K_ENTER);
    frame();
    frame();
  endtask

  task automatic end_game(input logic [13:0] sc, input logic with_esc);
    score_in[14 +: 14] = sc;
    game_over_in[1] = 1'b1;
    if (with_esc) begin
      keyboard = K_ESC;
      valid = 1'b1;
    end
    @(negedge clk2);
    game_over_in[1] = 1'b0;
    valid = 1'b0;
    keyboard = 8'h00;
  endtask

  initial begin
    // reset state
    cycles(2);
    exp_push(0); check("rst_state", state);
    exp_push(0); check("rst_cursor", cursor);
    exp_push(3'b111); check("rst_game_rst", game_rst);
    exp_push(0); check("rst_rgb", {red, green, blue});
    exp_push(0); check("rst_high", high_score);
    rst = 1'b0;
    cycles(2);
    exp_push(MENU_C); check("menu_rgb", {red, green, blue});

    // cursor wrap downward and upward
    key(K_DOWN); exp_push(1); check("down1", cursor);
    key(K_DOWN); exp_push(2); check("down2", cursor);
    key(K_DOWN); exp_push(0); check("down_wrap", cursor);
    exp_push(0); check("menu_state", state);
    exp_push(3'b111); check("menu_game_rst", game_rst);
    key(K_UP); exp_push(2); check("up_wrap", cursor);
    key(K_UP); exp_push(1); check("up1", cursor);
    key(8'h44); exp_push(1); check("other_key", cursor);

    // start sequence on game 1
    key(K_ENTER); exp_push(1); check("enter_start", state);
    frame(); exp_push(1); check("start_frame1", state);
    frame(); exp_push(2); check("start_play", state);
    exp_push(3'b101); check("play_game_rst", game_rst);
    exp_push(12'hA5C); check("play_rgb", {red, green, blue});

    // keyboard gating is combinational
    keyboard = K_ENTER; valid = 1'b1; #1;
    exp_push(3'b010); check("gv_enter", game_valid);
    @(negedge clk2);
    keyboard = K_ESC; #1;
    exp_push(0); check("gv_esc", game_valid);
    @(negedge clk2);
    valid = 1'b0; keyboard = 8'h00;
    exp_push(0); check("esc_menu", state);
    cycles(1);
    exp_push(3'b111); check("esc_game_rst", game_rst);

    // score recording
    start_game();
    end_game(14'd37, 1'b0);
    exp_push(3); check("over_state", state);
    exp_push(37); check("last37", last_score);
    exp_push(37); check("high1_37", high_score[14 +: 14]);
    exp_push(0); check("high0_0", high_score[0 +: 14]);
    key(K_ENTER); exp_push(0); check("over_enter", state);
    start_game();
    end_game(14'd20, 1'b0);
    exp_push(20); check("last20", last_score);
    exp_push(37); check("high_keep", high_score[14 +: 14]);
    start_game();
    end_game(14'd37, 1'b0);
    key(K_ENTER);
    exp_push(37); check("high_equal", high_score[14 +: 14]);

    // auto-return from OVER exactly on the 180th falling VS edge
    start_game();
    end_game(14'd5, 1'b0);
    for (int i = 0; i < 179; i++) frame();
    exp_push(3); check("hold_179", state);
    frame();
    exp_push(0); check("hold_180", state);

    // game_over beats ESC in the same cycle
    start_game();
    end_game(14'd50, 1'b1);
    exp_push(3); check("go_esc_state", state);
    exp_push(50); check("go_esc_last", last_score);
    exp_push(50); check("go_esc_high", high_score[14 +: 14]);
    key(K_ENTER);

    // reset mid-game
    start_game();
    exp_push(2); check("pre_rst_play", state);
    rst = 1'b1;
    @(negedge clk2);
    rst = 1'b0;
    exp_push(0); check("midrst_state", state);
    exp_push(0); check("midrst_cursor", cursor);
    exp_push(0); check("midrst_high", high_score);
    exp_push(0); check("midrst_rgb", {red, green, blue});
    exp_push(3'b111); check("midrst_game_rst", game_rst);
    exp_push(0); check("midrst_last", last_score);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_manager.md
Name: game_manager

Overview:
- Top-level session controller for the game console.
- Owns the menu/play/game-over sequence and selects which game core receives keyboard events and drives the VGA colour outputs.
- Generates per-game synchronous resets and latches the last score and per-game high scores.
- Sits between the keyboard decoder, the menu renderer, the game cores (each with game_over/score/RGB outputs) and the VGA output stage.

Parameters:
- NUM_GAMES, 3, number of attached game cores (2..4).
- OVER_HOLD_FRAMES, 180, frames the game-over screen stays up before auto-return to menu (1..255).
- START_FRAMES, 2, frames the selected game is held in reset before play starts (1..15).
- KEY_UP, 8'h1D, scan code moving the cursor up (W).
- KEY_DOWN, 8'h1B, scan code moving the cursor down (S).
- KEY_ENTER, 8'h5A, scan code selecting a game or confirming.
- KEY_ESC, 8'h76, scan code aborting a game.

Ports:
- clk2  in  1  system/pixel clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- VS  in  1  vertical sync from the VGA timing block.
- keyboard  in  8  scan code, qualified by valid.
- valid  in  1  one-cycle pulse, keyboard is valid.
- menu_rgb  in  12  {red,green,blue} from the menu renderer.
- game_rgb  in  12*NUM_GAMES  packed per-game {red,green,blue}; game g at [12g+11:12g].
- game_over_in  in  NUM_GAMES  per-game game_over.
- score_in  in  14*NUM_GAMES  packed per-game score, unsigned.
- game_rst  out  NUM_GAMES  per-game synchronous reset.
- game_valid  out  NUM_GAMES  gated keyboard valid per game.
- red, green, blue  out  4 each  selected colour, registered.
- cursor  out  2  menu highlight index, to the menu renderer.
- state  out  2  0=MENU, 1=START, 2=PLAY, 3=OVER.
- last_score  out  14  score of the most recently finished game.
- high_score  out  14*NUM_GAMES  packed per-game best score.

Behaviour:
- Reset values: state=MENU, cursor=0, active=0, game_rst all 1, game_valid 0, red/green/blue 0, last_score 0, all high_score 0, frame counters 0.
- A reset in any state, including mid-game, returns to these values. High scores are cleared.
- Frame tick: 3-bit shift register sampling VS each clk2. Tick = bits[2:1]==2'b10, i.e. one pulse per falling VS, 2-3 cycles after the edge.
- MENU:
  - valid & KEY_UP: cursor <= cursor-1; 0 wraps to NUM_GAMES-1.
  - valid & KEY_DOWN: cursor <= cursor+1; NUM_GAMES-1 wraps to 0.
  - valid & KEY_ENTER: active <= cursor, frame counter <= 0, state <= START.
  - Other codes are ignored.
- START: on each tick, counter++. When counter==START_FRAMES-1 and a tick occurs, go to PLAY. Keys are ignored.
- PLAY:
  - If game_over_in[active]==1: last_score <= score_in[active]. If score_in[active] > high_score[active], update high_score[active]. Clear counter, go to OVER.
  - Else if valid & KEY_ESC: go to MENU. last_score and high_score are unchanged.
  - game_over and ESC in the same cycle: game_over wins.
- OVER:
  - Each tick increments the counter. At counter==OVER_HOLD_FRAMES-1 with a tick, go to MENU.
  - valid & KEY_ENTER goes to MENU immediately.
  - ENTER and the final tick in the same cycle: go to MENU (single transition).
- game_rst[g] = 1 unless g==active and state is PLAY or OVER. This is registered, so it changes the cycle after the state changes. Inactive games are held in reset and stay frozen.
- game_valid[g] = valid & (g==active) & (state==PLAY) & (keyboard!=KEY_ESC). Combinational, zero latency, so keyboard data and valid stay aligned at the core.
- RGB mux: registered, 1-cycle latency.
  - MENU/START: menu_rgb.
  - PLAY/OVER: game_rgb of active.
  - active>=NUM_GAMES cannot occur. Cursor is clamped by the wrap logic.
- Score compare is unsigned 14-bit. Equal scores do not update the high score.

Test Plan:
- Reset then 3×KEY_DOWN pulses (NUM_GAMES=3) -> cursor 0→1→2→0. state stays 0. game_rst=3'b111.
- Cursor=1, KEY_ENTER -> state=1. After 2 VS falling edges, state=2 and game_rst=3'b101. A KEY_ENTER pulse then yields game_valid=3'b010; a KEY_ESC pulse yields game_valid=0, state=0, game_rst=3'b111.
- PLAY game 1 with score_in[1]=14'd37, pulse game_over_in[1] -> state=3, last_score=37, high_score[1]=37. Replay ending with score 20 -> last_score=20, high_score[1] stays 37.
- OVER with no keys, OVER_HOLD_FRAMES=180 -> state returns to 0 exactly on the 180th VS falling edge, not the 179th.
- PLAY: game_over_in[active] and valid with KEY_ESC in the same cycle -> state=3 and the score is recorded.
- PLAY: assert rst for 1 cycle -> next cycle state=0, cursor=0, high_score all 0, red/green/blue=0, game_rst all 1.
